fft_sample_loader: RTL and testbench

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

---
 rtl/fft_sample_loader.sv | 124 ++++++++++++
 tb/tb_fft_sample_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_loader.sv
// Gathers one 4-point complex frame from a serial beat stream and presents it as
// two radix-2 butterfly operand sets, (x0,x2) then (x1,x3), with the W0 twiddle.
module fft_sample_loader #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] a_re,
    output logic [BIT_WIDTH-1:0] a_im,
    output logic [BIT_WIDTH-1:0] b_re,
    output logic [BIT_WIDTH-1:0] b_im,
    output logic [BIT_WIDTH-1:0] weight_re,
    output logic [BIT_WIDTH-1:0] weight_im,
    output logic                 out_pair,
    output logic                 out_last
);

    typedef enum logic [1:0] {LOAD, EMIT0, EMIT1} state_t;

    state_t     state_reg, state_next;
    logic [2:0] beat_cnt_reg;
    logic       beat_accept;
    logic [1:0] wr_slot;

    // Flush wins over a beat presented in the same cycle.
    assign beat_accept = in_valid && in_ready && !flush;
    // Sample index is beat_cnt[2:1]; storing it bit-reversed puts each butterfly pair in adjacent slots.
    assign wr_slot     = {beat_cnt_reg[1], beat_cnt_reg[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                LOAD:    if (beat_accept && beat_cnt_reg == 3'd7) state_next = EMIT0;
                EMIT0:   if (out_ready) state_next = EMIT1;
                EMIT1:   if (out_ready) state_next = LOAD;
                default: state_next = LOAD;
            endcase
        end
    end

    // The counter wraps 7->0 exactly on the beat that moves LOAD to EMIT0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= 3'd0;
        end else if (flush) begin
            beat_cnt_reg <= 3'd0;
        end else if (beat_accept) begin
            beat_cnt_reg <= beat_cnt_reg + 3'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [BIT_WIDTH-1:0] re_reg;
            logic [BIT_WIDTH-1:0] im_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    re_reg <= '0;
                    im_reg <= '0;
                end else if (beat_accept && wr_slot == gi[1:0]) begin
                    if (beat_cnt_reg[0]) begin
                        im_reg <= in_data;
                    end else begin
                        re_reg <= in_data;
                    end
                end
            end
        end
    endgenerate

    assign weight_re = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    assign weight_im = '0;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_pair  = 1'b0;
        out_last  = 1'b0;
        a_re      = g_slot[0].re_reg;
        a_im      = g_slot[0].im_reg;
        b_re      = g_slot[1].re_reg;
        b_im      = g_slot[1].im_reg;
        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
            end
            EMIT0: begin
                out_valid = 1'b1;
            end
            EMIT1: begin
                out_valid = 1'b1;
                out_pair  = 1'b1;
                out_last  = 1'b1;
                a_re      = g_slot[2].re_reg;
                a_im      = g_slot[2].im_reg;
                b_re      = g_slot[3].re_reg;
                b_im      = g_slot[3].im_reg;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Drives directed and random beat/ready/flush traffic into fft_sample_loader and
// compares every cycle against a frame-level model built from queues.
module tb_fft_sample_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a_re, a_im, b_re, b_im, weight_re, weight_im;
    logic       out_pair, out_last;

    fft_sample_loader #(.BIT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .weight_re(weight_re), .weight_im(weight_im),
        .out_pair(out_pair), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ar, ai, br, bi;
        logic       pair;
    } pair_t;

    logic [7:0] beats[$];
    pair_t      pend[$];
    int         check_cnt = 0;
    int         pass_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        beats.delete();
        pend.delete();
    endtask

    // One clock: drive on the falling edge, compare, then advance the model at the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f, output logic took);
        pair_t p0, p1;
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = r; flush = f;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, pend.size() == 0});
        check("out_valid", {31'd0, out_valid}, {31'd0, pend.size() != 0});
        check("weight_re", {24'd0, weight_re}, 32'h7F);
        check("weight_im", {24'd0, weight_im}, 32'h00);
        if (pend.size() != 0) begin
            check("a_re", {24'd0, a_re}, {24'd0, pend[0].ar});
            check("a_im", {24'd0, a_im}, {24'd0, pend[0].ai});
            check("b_re", {24'd0, b_re}, {24'd0, pend[0].br});
            check("b_im", {24'd0, b_im}, {24'd0, pend[0].bi});
            check("out_pair", {31'd0, out_pair}, {31'd0, pend[0].pair});
            check("out_last", {31'd0, out_last}, {31'd0, pend[0].pair});
        end
        @(posedge clk);
        took = 1'b0;
        if (f) begin
            model_reset();
        end else if (pend.size() != 0) begin
            if (r) void'(pend.pop_front());
        end else if (v) begin
            took = 1'b1;
            beats.push_back(d);
            if (beats.size() == 8) begin
                p0 = '{beats[0], beats[1], beats[4], beats[5], 1'b0};
                p1 = '{beats[2], beats[3], beats[6], beats[7], 1'b1};
                pend.push_back(p0);
                pend.push_back(p1);
                beats.delete();
            end
        end
    endtask

    // Presents n beats with in_valid held high, advancing only when a beat is taken.
    task automatic feed(input logic [7:0] fr[16], input int n, input logic r);
        int   idx = 0;
        int   budget = 0;
        logic took;
        while (idx < n && budget < 200) begin
            step(1'b1, fr[idx], r, 1'b0, took);
            if (took) idx++;
            budget++;
        end
        check("feed_done", idx, n);
    endtask

    task automatic idle(input int n, input logic r);
        logic took;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r, 1'b0, took);
    endtask

    initial begin
        logic [7:0] f1[16];
        logic [7:0] f2[16];
        logic [7:0] fx[16];
        logic       took;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_a_re", {24'd0, a_re}, 32'd0);
        check("rst_b_im", {24'd0, b_im}, 32'd0);
        check("rst_weight_re", {24'd0, weight_re}, 32'h7F);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        f1 = '{8'h10, 8'h01, 8'h20, 8'h02, 8'h30, 8'h03, 8'h40, 8'h04,
               8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h41, 8'h42};
        // Basic frame, then the same frame with downstream stalled for five cycles.
        feed(f1, 8, 1'b1);
        check("pair0_a_re_literal", {24'd0, a_re}, 32'h10);
        check("pair0_b_re_literal", {24'd0, b_re}, 32'h30);
        idle(2, 1'b1);
        feed(f1, 8, 1'b1);
        idle(5, 1'b0);
        idle(2, 1'b1);

        // Back-to-back frames with in_valid never dropping.
        feed(f1, 16, 1'b1);
        idle(2, 1'b1);

        // Partial frame aborted by flush, with a beat presented during the flush.
        f2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        feed(f2, 5, 1'b1);
        step(1'b1, 8'hEE, 1'b1, 1'b1, took);
        feed(f1, 8, 1'b1);
        idle(2, 1'b1);

        // Signed extremes pass through bit-exact.
        fx = '{8'h80, 8'h80, 8'h01, 8'hFF, 8'h7F, 8'h7F, 8'h00, 8'h80,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        feed(fx, 8, 1'b1);
        check("ext_a_re", {24'd0, a_re}, 32'h80);
        check("ext_b_im", {24'd0, b_im}, 32'h7F);
        idle(2, 1'b1);

        // Asynchronous reset while the second pair is on the outputs.
        feed(f1, 8, 1'b1);
        idle(1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("pre_rst_out_last", {31'd0, out_last}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_a_re", {24'd0, a_re}, 32'd0);
        check("arst_a_im", {24'd0, a_im}, 32'd0);
        check("arst_b_re", {24'd0, b_re}, 32'd0);
        check("arst_b_im", {24'd0, b_im}, 32'd0);
        check("arst_out_pair", {31'd0, out_pair}, 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        feed(f1, 8, 1'b1);
        idle(2, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, took);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
